audio_dac_tx: RTL and testbench

Stereo I2S transmitter that takes processed 32-bit samples from the effects chain (distortion and later stages) and serialises them to the audio codec DAC. Generates the bit clock and left/right clock as interface master, reduces each sample to the DAC word width, and buffers one stereo pair so the effects chain can deliver a frame early.

---
 rtl/audio_pkg.sv | 41 ++++
 rtl/aud_clkgen.sv | 47 ++++
 rtl/audio_dac_tx.sv | 107 ++++++++++
 tb/tb_audio_dac_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants, stereo-pair payload and sample width reduction for the I2S DAC path.
// Defining AUDIO_DAC_TX_SAT_EN makes dac_reduce saturate instead of wrap.
package audio_pkg;

  localparam int unsigned FRAME_SLOTS = 64;
  localparam int unsigned HALF_SLOTS  = 32;
  localparam int unsigned SAMPLE_W    = 32;
  localparam int unsigned SLOT_W      = 6;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] L;
    logic signed [SAMPLE_W-1:0] R;
  } stereo_pair_t;

  // Scale a sample down and fit it into 'width' bits; result is masked to 'width' bits.
  function automatic logic [SAMPLE_W-1:0] dac_reduce(
    input logic signed [SAMPLE_W-1:0] sample,
    input int unsigned                shift,
    input int unsigned                width
  );
    logic signed [SAMPLE_W-1:0] w;
    logic        [SAMPLE_W-1:0] mask;
`ifdef AUDIO_DAC_TX_SAT_EN
    logic signed [SAMPLE_W-1:0] max_v;
    logic signed [SAMPLE_W-1:0] min_v;
`endif
    w    = sample >>> shift;
    mask = (SAMPLE_W'(1) << width) - SAMPLE_W'(1);
`ifdef AUDIO_DAC_TX_SAT_EN
    max_v = $signed((SAMPLE_W'(1) << (width - 1)) - SAMPLE_W'(1));
    min_v = ~max_v;
    if (w > max_v) begin
      w = max_v;
    end else if (w < min_v) begin
      w = min_v;
    end
`endif
    return SAMPLE_W'(w) & mask;
  endfunction

endpackage

// File: rtl/aud_clkgen.sv
// I2S master timing: BCLK divider, LRCK and the 64-slot frame counter.
// fall_evt/load_evt mark the cycle in which BCLK is about to fall.
module aud_clkgen
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              bclk,
  output logic              lrck,
  output logic              fall_evt,
  output logic              load_evt,
  output logic [SLOT_W-1:0] bit_cnt
);

  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0]  div_cnt;
  logic              tc;
  logic [SLOT_W-1:0] bit_cnt_nxt;

  assign tc          = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign fall_evt    = tc && bclk;
  assign bit_cnt_nxt = bit_cnt + SLOT_W'(1);
  assign load_evt    = fall_evt && (bit_cnt == SLOT_W'(FRAME_SLOTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      lrck    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + DIV_W'(1);
      if (tc) begin
        bclk <= ~bclk;
      end
      // Slot counter and channel select only move on BCLK falling events.
      if (fall_evt) begin
        bit_cnt <= bit_cnt_nxt;
        lrck    <= (bit_cnt_nxt >= SLOT_W'(HALF_SLOTS));
      end
    end
  end

endmodule

// File: rtl/audio_dac_tx.sv
// Stereo I2S master transmitter with a one-pair holding register and sticky underrun flag.
// Define AUDIO_DAC_TX_SAT_EN for saturating width reduction (default: wrap-around).
module audio_dac_tx
  import audio_pkg::*;
#(
  parameter int unsigned DAC_W      = 24,
  parameter int unsigned FRAC_SHIFT = 8,
  parameter int unsigned BCLK_DIV   = 8
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] in_L,
  input  logic signed [SAMPLE_W-1:0] in_R,
  output logic                       AUD_BCLK,
  output logic                       AUD_DACLRCK,
  output logic                       AUD_DACDAT,
  output logic                       underrun
);

  stereo_pair_t      hold;
  logic              hold_full;
  logic              primed;
  logic              accept;
  logic              fall_evt;
  logic              load_evt;
  logic [SLOT_W-1:0] bit_cnt;
  logic [SLOT_W-1:0] slot_nxt;
  logic [4:0]        half_pos;
  logic              in_data;
  logic              tx_right;
  logic [DAC_W-1:0]  word_l;
  logic [DAC_W-1:0]  word_r;
  logic [DAC_W-1:0]  sh_l;
  logic [DAC_W-1:0]  sh_r;

  aud_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
    .clk      (CLOCK_50),
    .rst_n    (reset_n),
    .bclk     (AUD_BCLK),
    .lrck     (AUD_DACLRCK),
    .fall_evt (fall_evt),
    .load_evt (load_evt),
    .bit_cnt  (bit_cnt)
  );

  assign accept   = in_valid && !hold_full;
  assign slot_nxt = bit_cnt + SLOT_W'(1);
  assign half_pos = slot_nxt[4:0];
  assign tx_right = slot_nxt[SLOT_W-1];
  // One-slot I2S delay: half-slots 1..DAC_W carry the word, everything else is 0.
  assign in_data  = (half_pos != '0) && (32'(half_pos) <= DAC_W);
  assign word_l   = DAC_W'(dac_reduce(hold.L, FRAC_SHIFT, DAC_W));
  assign word_r   = DAC_W'(dac_reduce(hold.R, FRAC_SHIFT, DAC_W));

  // Holding register; a load in the same cycle as an accept sees the old (empty) state.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
      in_ready  <= 1'b1;
      primed    <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (accept) begin
        hold.L <= in_L;
        hold.R <= in_R;
        primed <= 1'b1;
      end
      if (load_evt && hold_full) begin
        hold_full <= 1'b0;
        in_ready  <= 1'b1;
      end else if (accept) begin
        hold_full <= 1'b1;
        in_ready  <= 1'b0;
      end
      if (load_evt && !hold_full && primed) begin
        underrun <= 1'b1;
      end
    end
  end

  // Per-channel shift registers, MSB first, updated only on BCLK falling events.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sh_l       <= '0;
      sh_r       <= '0;
      AUD_DACDAT <= 1'b0;
    end else if (load_evt) begin
      sh_l       <= hold_full ? word_l : '0;
      sh_r       <= hold_full ? word_r : '0;
      AUD_DACDAT <= 1'b0;
    end else if (fall_evt) begin
      if (in_data && tx_right) begin
        AUD_DACDAT <= sh_r[DAC_W-1];
        sh_r       <= {sh_r[DAC_W-2:0], 1'b0};
      end else if (in_data) begin
        AUD_DACDAT <= sh_l[DAC_W-1];
        sh_l       <= {sh_l[DAC_W-2:0], 1'b0};
      end else begin
        AUD_DACDAT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Directed bench for audio_dac_tx: frame capture on BCLK rising edges against hand-computed words.
// Second instance uses FRAC_SHIFT=0 so the AUDIO_DAC_TX_SAT_EN overflow handling is reachable.
`timescale 1ns/1ps
module tb_audio_dac_tx;

  logic        clk;
  logic        reset_n;
  logic        v0, v1;
  logic [31:0] l0, r0, l1, r1;
  logic        rdy0, rdy1, bclk0, bclk1, lr0, lr1, dat0, dat1, ur0, ur1;

  int errors = 0;
  int checks = 0;

  audio_dac_tx u_dut (
    .CLOCK_50(clk), .reset_n(reset_n), .in_valid(v0), .in_ready(rdy0),
    .in_L(l0), .in_R(r0), .AUD_BCLK(bclk0), .AUD_DACLRCK(lr0),
    .AUD_DACDAT(dat0), .underrun(ur0)
  );

  audio_dac_tx #(.DAC_W(24), .FRAC_SHIFT(0), .BCLK_DIV(8)) u_dut_sat (
    .CLOCK_50(clk), .reset_n(reset_n), .in_valid(v1), .in_ready(rdy1),
    .in_L(l1), .in_R(r1), .AUD_BCLK(bclk1), .AUD_DACLRCK(lr1),
    .AUD_DACDAT(dat1), .underrun(ur1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] l;
    logic [31:0] r;
    logic [23:0] wl;
    logic [23:0] wr;
    string       name;
  } vec_t;

  vec_t vecs[10];

  localparam logic [63:0] LR_EXP = {32'hFFFF_FFFF, 32'h0000_0000};

`ifdef AUDIO_DAC_TX_SAT_EN
  localparam logic [23:0] OVF_MAX_L = 24'h7FFFFF, OVF_MIN_R = 24'h800000;
  localparam logic [23:0] BIG_L     = 24'h7FFFFF, BIG_R     = 24'h800000;
`else
  localparam logic [23:0] OVF_MAX_L = 24'hFFFFFF, OVF_MIN_R = 24'h000000;
  localparam logic [23:0] BIG_L     = 24'h800000, BIG_R     = 24'h7FFFFF;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [23:0] wl, input logic [23:0] wr);
    logic [63:0] f;
    f = '0;
    for (int k = 1; k <= 24; k++) begin
      f[k]      = wl[24-k];
      f[32 + k] = wr[24-k];
    end
    return f;
  endfunction

  // kind 0: BCLK rise, 1: LRCK fall, 2: BCLK fall (instance 0). n = cycles waited, -1 on timeout.
  task automatic wait_edge(input int kind, output int n);
    logic p, s;
    p = (kind == 1) ? lr0 : bclk0;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      s = (kind == 1) ? lr0 : bclk0;
      if ((kind == 0 && !p && s) || (kind != 0 && p && !s)) break;
      p = s;
      if (n > 5000) begin
        n = -1;
        break;
      end
    end
  endtask

  // Wait for the next frame start, then sample DAT/LRCK on each of the 64 BCLK rising edges.
  task automatic capture_frame(input int sel, output logic [63:0] d, output logic [63:0] lr);
    logic pl, l, pb, b;
    int   n, slot;
    bit   ok;
    d  = '0;
    lr = '0;
    ok = 1'b1;
    n  = 0;
    pl = (sel == 1) ? lr1 : lr0;
    forever begin
      @(negedge clk);
      n++;
      l = (sel == 1) ? lr1 : lr0;
      if (pl && !l) break;
      pl = l;
      if (n > 3000) begin
        ok = 1'b0;
        break;
      end
    end
    slot = 0;
    n    = 0;
    pb   = (sel == 1) ? bclk1 : bclk0;
    while (ok && slot < 64 && n < 3000) begin
      @(negedge clk);
      n++;
      b = (sel == 1) ? bclk1 : bclk0;
      if (b && !pb) begin
        d[slot]  = (sel == 1) ? dat1 : dat0;
        lr[slot] = (sel == 1) ? lr1 : lr0;
        slot++;
      end
      pb = b;
    end
    if (slot < 64) begin
      checks++;
      errors++;
      $display("FAIL capture_frame: got %0d slots required 64", slot);
    end
  endtask

  task automatic send_pair(input int sel, input logic [31:0] l, input logic [31:0] r,
                           input string name);
    int n;
    n = 0;
    while (!((sel == 1) ? rdy1 : rdy0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready"}, 64'((sel == 1) ? rdy1 : rdy0), 64'd1);
    if (sel == 1) begin
      v1 = 1'b1; l1 = l; r1 = r;
    end else begin
      v0 = 1'b1; l0 = l; r0 = r;
    end
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Release reset and time the first LRCK rise and the first frame boundary.
  task automatic release_timed(input string name);
    logic pl, l;
    int   n, rise_t, fall_t;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0; rise_t = -1; fall_t = -1;
    pl = lr0;
    while (n < 5000) begin
      @(negedge clk);
      n++;
      l = lr0;
      if (!pl && l && rise_t < 0) rise_t = n;
      if (pl && !l) begin
        fall_t = n;
        break;
      end
      pl = l;
    end
    check({name, "_lrck_rise_cycles"}, 64'(rise_t), 64'd512);
    check({name, "_first_frame_cycles"}, 64'(fall_t), 64'd1024);
  endtask

  initial begin
    logic [63:0] d, lr;
    int          n, acc, falls, viol;
    logic        expect_low, pl;

    vecs[0] = '{0, 32'h0123_4500, 32'hFFFF_FF00, 24'h012345, 24'hFFFFFF, "ref_pair"};
    vecs[1] = '{0, 32'h8000_0000, 32'h7FFF_FFFF, 24'h800000, 24'h7FFFFF, "full_scale"};
    vecs[2] = '{0, 32'h0000_00FF, 32'h0000_0100, 24'h000000, 24'h000001, "frac_bits"};
    vecs[3] = '{0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 24'hA5A5A5, 24'h5A5A5A, "alt_bits"};
    vecs[4] = '{0, 32'h0000_0000, 32'hFFFF_FFFF, 24'h000000, 24'hFFFFFF, "zero_neg"};
    vecs[5] = '{1, 32'h7FFF_FFFF, 32'h8000_0000, OVF_MAX_L, OVF_MIN_R, "ovf_extremes"};
    vecs[6] = '{1, 32'h0080_0000, 32'hFF7F_FFFF, BIG_L, BIG_R, "ovf_by_one"};
    vecs[7] = '{1, 32'h007F_FFFF, 32'hFF80_0000, 24'h7FFFFF, 24'h800000, "range_edges"};
    vecs[8] = '{1, 32'h0012_3456, 32'hFFFF_FFFF, 24'h123456, 24'hFFFFFF, "in_range"};
    vecs[9] = '{0, 32'h0123_4500, 32'hFFFF_FF00, 24'h012345, 24'hFFFFFF, "ref_again"};

    reset_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    l0 = '0; r0 = '0; l1 = '0; r1 = '0;
    repeat (3) @(negedge clk);

    check("rst_bclk", 64'(bclk0), 64'd0);
    check("rst_lrck", 64'(lr0), 64'd0);
    check("rst_dat", 64'(dat0), 64'd0);
    check("rst_in_ready", 64'(rdy0), 64'd1);
    check("rst_underrun", 64'(ur0), 64'd0);

    release_timed("boot");

    // Idle: no input, so silent frames and no underrun (never primed).
    wait_edge(0, n);
    wait_edge(0, n);
    check("bclk_period", 64'(n), 64'd16);
    wait_edge(1, n);
    wait_edge(1, n);
    check("lrck_period", 64'(n), 64'd1024);
    for (int f = 0; f < 3; f++) begin
      capture_frame(0, d, lr);
      check($sformatf("idle_frame%0d_dat", f), d, 64'd0);
      if (f == 0) check("idle_lrck_pattern", lr, LR_EXP);
    end
    check("idle_underrun", 64'(ur0), 64'd0);

    // Streaming: in_valid held high with fresh data after each accept.
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    v0 = 1'b1; l0 = 32'h0001_0000; r0 = 32'h0002_0000;
    acc = 1; falls = 0; viol = 0; expect_low = 1'b1; pl = lr0; n = 0;
    while (n < 20000) begin
      @(negedge clk);
      n++;
      if (expect_low) begin
        if (rdy0) viol++;
        expect_low = 1'b0;
        l0 = l0 + 32'h100;
        r0 = r0 - 32'h100;
      end
      if (pl && !lr0) begin
        falls++;
        if (falls == 10) break;
      end
      pl = lr0;
      if (rdy0) begin
        acc++;
        expect_low = 1'b1;
      end
    end
    v0 = 1'b0;
    check("stream_accepts", 64'(acc), 64'd10);
    check("stream_ready_low_after_accept", 64'(viol), 64'd0);
    check("stream_underrun", 64'(ur0), 64'd0);

    // Input stopped: next frame is silent and underrun latches.
    capture_frame(0, d, lr);
    check("underrun_frame_dat", d, 64'd0);
    check("underrun_set", 64'(ur0), 64'd1);
    capture_frame(0, d, lr);
    check("underrun_sticky", 64'(ur0), 64'd1);

    do_reset();
    check("underrun_cleared", 64'(ur0), 64'd0);

    for (int i = 0; i < 10; i++) begin
      send_pair(vecs[i].sel, vecs[i].l, vecs[i].r, vecs[i].name);
      capture_frame(vecs[i].sel, d, lr);
      check({vecs[i].name, "_dat"}, d, exp_frame(vecs[i].wl, vecs[i].wr));
      check({vecs[i].name, "_lrck"}, lr, LR_EXP);
    end

    // Reset mid-frame at bit_cnt=40 while the right channel is sending ones.
    send_pair(0, 32'h0123_4500, 32'hFFFF_FF00, "midrst");
    wait_edge(1, n);
    for (int k = 0; k < 40; k++) wait_edge(2, n);
    check("pre_reset_lrck", 64'(lr0), 64'd1);
    check("pre_reset_dat", 64'(dat0), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_bclk", 64'(bclk0), 64'd0);
    check("midrst_lrck", 64'(lr0), 64'd0);
    check("midrst_dat", 64'(dat0), 64'd0);
    check("midrst_in_ready", 64'(rdy0), 64'd1);
    check("midrst_underrun", 64'(ur0), 64'd0);
    release_timed("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
